cpu_control_sequencer: RTL and testbench

Hardwired control unit that sequences the CPU datapath through fetch, decode and execute for register-register ALU instructions. It replaces hand-driven bus select and register-enable strobes with a state machine. The state machine decodes IR fields and handshakes with memory on instruction fetch. It sits beside the datapath: it drives bus source selection, register load enables and `alu_op`, and it reads the IR contents back.

---
 rtl/cpu_ctrl_pkg.sv | 45 ++++
 rtl/ctrl_decode.sv | 29 ++
 rtl/cpu_control_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the hardwired control sequencer.
// Optional MUL/DIV support is selected by the CTRL_MULDIV_EN macro.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  localparam logic [2:0] C_ALU     = 3'd0;
  localparam logic [2:0] C_MULDIV  = 3'd1;
  localparam logic [2:0] C_NOP     = 3'd2;
  localparam logic [2:0] C_HALT    = 3'd3;
  localparam logic [2:0] C_ILLEGAL = 3'd4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_DIV = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_INC = 4'b1111;

  localparam logic [4:0] BUS_HI   = 5'd16;
  localparam logic [4:0] BUS_LO   = 5'd17;
  localparam logic [4:0] BUS_ZHI  = 5'd18;
  localparam logic [4:0] BUS_ZLO  = 5'd19;
  localparam logic [4:0] BUS_PC   = 5'd20;
  localparam logic [4:0] BUS_MDR  = 5'd21;
  localparam logic [4:0] BUS_NONE = 5'd31;

  localparam int IR_OP_LO = 27;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_LO = 15;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into instruction class and ALU function.
// MUL/DIV decode only when CTRL_MULDIV_EN is defined; otherwise they are illegal.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [2:0] op_class,
  output logic [3:0] alu_op
);

  always_comb begin
    op_class = C_ILLEGAL;
    alu_op   = ALU_ADD;
    case (opcode)
      OP_ADD:  begin op_class = C_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = C_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin op_class = C_ALU; alu_op = ALU_AND; end
      OP_OR:   begin op_class = C_ALU; alu_op = ALU_OR;  end
`ifdef CTRL_MULDIV_EN
      OP_MUL:  begin op_class = C_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin op_class = C_MULDIV; alu_op = ALU_DIV; end
`endif
      OP_NOP:  op_class = C_NOP;
      OP_HALT: op_class = C_HALT;
      default: op_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute sequencer for register-register ALU instructions.
// CTRL_MULDIV_EN enables the MUL/DIV path through T6 (HI/LO writeback).
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_GPR = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [31:0]        ir,
  input  logic               mem_ready,
  output logic [4:0]         bus_sel,
  output logic [NUM_GPR-1:0] reg_in,
  output logic               pc_in,
  output logic               mar_in,
  output logic               mdr_in,
  output logic               ir_in,
  output logic               ry_in,
  output logic               zlow_in,
  output logic               zhigh_in,
  output logic               hi_in,
  output logic               lo_in,
  output logic               md_read,
  output logic               mem_req,
  output logic [3:0]         alu_op,
  output logic               halted,
  output logic               illegal_op,
  output logic [15:0]        inst_count
);

  state_t     state;
  logic [2:0] op_class;
  logic [3:0] dec_alu;
  logic [3:0] ra, rb, rc;
  logic       retire;
  logic       unused_ir_bits;

  assign ra = ir[IR_RA_LO +: 4];
  assign rb = ir[IR_RB_LO +: 4];
  assign rc = ir[IR_RC_LO +: 4];
  assign unused_ir_bits = ^ir[IR_RC_LO-1:0];

  ctrl_decode u_dec (
    .opcode   (ir[IR_OP_LO +: 5]),
    .op_class (op_class),
    .alu_op   (dec_alu)
  );

  // Retirement points: NOP/illegal at decode, ALU ops at T5, MUL/DIV at T6.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_T3:    retire = (op_class == C_NOP) || (op_class == C_ILLEGAL);
      S_T5:    retire = (op_class == C_ALU);
      S_T6:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      inst_count <= '0;
    end else if (retire) begin
      inst_count <= inst_count + 16'd1;
      state      <= run ? S_T0 : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (mem_ready) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= (op_class == C_HALT) ? S_HALT : S_T4;
        S_T4:   state <= S_T5;
        S_T5:   state <= S_T6;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_sel    = BUS_NONE;
    reg_in     = '0;
    pc_in      = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    ir_in      = 1'b0;
    ry_in      = 1'b0;
    zlow_in    = 1'b0;
    zhigh_in   = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    md_read    = 1'b0;
    mem_req    = 1'b0;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_T0: begin
        bus_sel = BUS_PC;
        mar_in  = 1'b1;
        alu_op  = ALU_INC;
        zlow_in = 1'b1;
      end
      S_T1: begin
        bus_sel = BUS_ZLO;
        pc_in   = 1'b1;
        mem_req = 1'b1;
        md_read = 1'b1;
        mdr_in  = 1'b1;
      end
      S_T2: begin
        bus_sel = BUS_MDR;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (op_class == C_ALU || op_class == C_MULDIV) begin
          bus_sel = {1'b0, rb};
          ry_in   = 1'b1;
        end
        illegal_op = (op_class == C_ILLEGAL);
      end
      S_T4: begin
        bus_sel = {1'b0, rc};
        alu_op  = dec_alu;
        zlow_in = 1'b1;
`ifdef CTRL_MULDIV_EN
        zhigh_in = (op_class == C_MULDIV);
`endif
      end
      S_T5: begin
        bus_sel = BUS_ZLO;
        if (op_class == C_ALU)
          reg_in = {{(NUM_GPR-1){1'b0}}, 1'b1} << ra;
`ifdef CTRL_MULDIV_EN
        lo_in = (op_class == C_MULDIV);
`endif
      end
      S_T6: begin
`ifdef CTRL_MULDIV_EN
        bus_sel = BUS_ZHI;
        hi_in   = 1'b1;
`endif
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Table-driven cycle-by-cycle check of the control sequencer outputs,
// plus hand-written HALT hold and mid-instruction reset sequences.
module tb_cpu_control_sequencer;

  logic        clk, reset, run, mem_ready;
  logic [31:0] ir;
  logic [4:0]  bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, mar_in, mdr_in, ir_in, ry_in, zlow_in, zhigh_in, hi_in, lo_in;
  logic        md_read, mem_req, halted, illegal_op;
  logic [3:0]  alu_op;
  logic [15:0] inst_count;

  cpu_control_sequencer #(.NUM_GPR(16)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
    .bus_sel(bus_sel), .reg_in(reg_in), .pc_in(pc_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .ir_in(ir_in), .ry_in(ry_in), .zlow_in(zlow_in),
    .zhigh_in(zhigh_in), .hi_in(hi_in), .lo_in(lo_in), .md_read(md_read),
    .mem_req(mem_req), .alu_op(alu_op), .halted(halted),
    .illegal_op(illegal_op), .inst_count(inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] PC = 11'h400, MAR = 11'h200, MDR = 11'h100, IRI = 11'h080,
                          RY = 11'h040, ZL = 11'h020, ZH = 11'h010, HI = 11'h008,
                          LO = 11'h004, MDRD = 11'h002, MREQ = 11'h001;
  localparam logic [10:0] T1S = PC | MREQ | MDRD | MDR;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [4:0]  bus;
    logic [15:0] regin;
    logic [10:0] stb;
    logic [3:0]  alu;
    logic        halted;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  wire [10:0] stb_act = {pc_in, mar_in, mdr_in, ir_in, ry_in, zlow_in, zhigh_in,
                         hi_in, lo_in, md_read, mem_req};

  function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  task automatic add(logic r, logic m, logic [31:0] i, logic [4:0] b, logic [15:0] rg,
                     logic [10:0] s, logic [3:0] a, logic h, logic il, logic [15:0] c);
    vec_t v;
    v.run = r; v.mr = m; v.ir = i; v.bus = b; v.regin = rg; v.stb = s;
    v.alu = a; v.halted = h; v.ill = il; v.cnt = c;
    tbl.push_back(v);
  endtask

  // T0, T1 with mem_ready on first cycle, T2
  task automatic fetch(logic [31:0] i, logic [15:0] c);
    add(1, 0, i, 20, 0, MAR | ZL, 4'hF, 0, 0, c);
    add(1, 1, i, 19, 0, T1S, 4'h0, 0, 0, c);
    add(1, 0, i, 21, 0, IRI, 4'h0, 0, 0, c);
  endtask

  task automatic chk(string name, vec_t v);
    n_chk++;
    if (bus_sel !== v.bus || reg_in !== v.regin || stb_act !== v.stb || alu_op !== v.alu ||
        halted !== v.halted || illegal_op !== v.ill || inst_count !== v.cnt) begin
      n_fail++;
      $display("FAIL %s: got bus=%0d reg_in=%h stb=%h alu=%h halted=%b ill=%b cnt=%0d; expected bus=%0d reg_in=%h stb=%h alu=%h halted=%b ill=%b cnt=%0d",
               name, bus_sel, reg_in, stb_act, alu_op, halted, illegal_op, inst_count,
               v.bus, v.regin, v.stb, v.alu, v.halted, v.ill, v.cnt);
    end
  endtask

  task automatic step(string name, vec_t v);
    @(negedge clk);
    run = v.run; mem_ready = v.mr; ir = v.ir;
    #1 chk(name, v);
  endtask

  logic [31:0] i_add, i_div, i_ill, i_nop, i_and, i_halt, i_or;
  vec_t idle_v, w;

  initial begin
    i_add  = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
    i_div  = 32'h4A92_0000;
    i_ill  = mk_ir(5'b11111, 4'd3, 4'd4, 4'd5);
    i_nop  = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
    i_and  = mk_ir(5'b00101, 4'd7, 4'd8, 4'd9);
    i_halt = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
    i_or   = mk_ir(5'b00110, 4'd1, 4'd2, 4'd3);

    // ADD R1,R2,R3 with three wait cycles in T1
    add(1, 0, i_add, 20, 0, MAR | ZL, 4'hF, 0, 0, 0);
    add(1, 0, i_add, 19, 0, T1S, 4'h0, 0, 0, 0);
    add(1, 0, i_add, 19, 0, T1S, 4'h0, 0, 0, 0);
    add(1, 0, i_add, 19, 0, T1S, 4'h0, 0, 0, 0);
    add(1, 1, i_add, 19, 0, T1S, 4'h0, 0, 0, 0);
    add(1, 0, i_add, 21, 0, IRI, 4'h0, 0, 0, 0);
    add(1, 0, i_add, 2, 0, RY, 4'h0, 0, 0, 0);
    add(1, 0, i_add, 3, 0, ZL, 4'h0, 0, 0, 0);
    add(1, 0, i_add, 19, 16'h0002, 0, 4'h0, 0, 0, 0);
    // DIV R5,R2,R4
    fetch(i_div, 1);
`ifdef CTRL_MULDIV_EN
    add(1, 0, i_div, 2, 0, RY, 4'h0, 0, 0, 1);
    add(1, 0, i_div, 4, 0, ZL | ZH, 4'h2, 0, 0, 1);
    add(1, 0, i_div, 19, 0, LO, 4'h0, 0, 0, 1);
    add(1, 0, i_div, 18, 0, HI, 4'h0, 0, 0, 1);
`else
    add(1, 0, i_div, 31, 0, 0, 4'h0, 0, 1, 1);
`endif
    // undecoded opcode
    fetch(i_ill, 2);
    add(1, 0, i_ill, 31, 0, 0, 4'h0, 0, 1, 2);
    // NOP; mem_ready pulse in T0 must be ignored
    add(1, 1, i_nop, 20, 0, MAR | ZL, 4'hF, 0, 0, 3);
    add(1, 0, i_nop, 19, 0, T1S, 4'h0, 0, 0, 3);
    add(1, 1, i_nop, 19, 0, T1S, 4'h0, 0, 0, 3);
    add(1, 0, i_nop, 21, 0, IRI, 4'h0, 0, 0, 3);
    add(1, 0, i_nop, 31, 0, 0, 4'h0, 0, 0, 3);
    // AND R7,R8,R9 with run dropped in T4
    fetch(i_and, 4);
    add(1, 0, i_and, 8, 0, RY, 4'h0, 0, 0, 4);
    add(0, 0, i_and, 9, 0, ZL, 4'h4, 0, 0, 4);
    add(0, 0, i_and, 19, 16'h0080, 0, 4'h0, 0, 0, 4);
    add(0, 0, i_and, 31, 0, 0, 4'h0, 0, 0, 5);
    add(1, 0, i_and, 31, 0, 0, 4'h0, 0, 0, 5);
    // HALT
    fetch(i_halt, 5);
    add(1, 0, i_halt, 31, 0, 0, 4'h0, 0, 0, 5);
    add(1, 0, i_halt, 31, 0, 0, 4'h0, 1, 0, 5);

    idle_v = '{run: 1, mr: 0, ir: i_add, bus: 31, regin: 0, stb: 0, alu: 0, halted: 0, ill: 0, cnt: 0};

    reset = 1'b0; run = 1'b1; mem_ready = 1'b0; ir = i_add;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("reset_state", idle_v);
    reset = 1'b1;

    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k]);

    w = idle_v; w.halted = 1; w.cnt = 5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      run = 1'b1;
      #1 chk($sformatf("halt_hold%0d", k), w);
    end

    @(negedge clk);
    reset = 1'b0;
    #1 chk("halt_reset", idle_v);
    ir = i_or;
    @(negedge clk);
    reset = 1'b1;

    // OR with reset in T4: abandoned, no retire
    w = idle_v; w.ir = i_or; w.bus = 20; w.stb = MAR | ZL; w.alu = 4'hF;
    step("or_t0", w);
    w.mr = 1; w.bus = 19; w.stb = T1S; w.alu = 0;
    step("or_t1", w);
    w.mr = 0; w.bus = 21; w.stb = IRI;
    step("or_t2", w);
    w.bus = 2; w.stb = RY;
    step("or_t3", w);
    w.bus = 3; w.stb = ZL; w.alu = 4'h5;
    step("or_t4", w);
    #1 reset = 1'b0;
    #1 chk("or_reset_t4", idle_v);
    @(negedge clk);
    reset = 1'b1; run = 1'b0;
    w = idle_v; w.run = 0; w.ir = i_or;
    step("idle_after_reset", w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
